bridge_rx: RTL and testbench

- Receive-side protocol bridge that parses ASCII hex command lines from the UART receiver.
- Each valid line becomes a single read or write request on the internal request bus (address, data, rw, valid/ready) that drives the register/memory cores.
- Malformed lines are rejected and never produce a request.

---
 rtl/bridge_pkg.sv | 30 +++
 rtl/bridge_rx.sv | 133 +++++++++++++
 tb/tb_bridge_rx.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the ASCII hex command-line receive bridge:
// FSM state encoding, framing characters and hex-digit decoding helpers.
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        TRANSMIT,
        ERROR
    } state_t;

    localparam logic [7:0] CHAR_M  = 8'h4D;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    function automatic logic is_hex(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) ||
               (b >= 8'h41 && b <= 8'h46) ||
               (b >= 8'h61 && b <= 8'h66);
    endfunction

    // Upper and lower case letters share their low nibble, so one offset covers both.
    function automatic logic [3:0] hex_to_nibble(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39)
            return b[3:0];
        else
            return b[3:0] + 4'd9;
    endfunction

endpackage

// File: rtl/bridge_rx.sv
// Parses 'M'-prefixed hex command lines from the UART receiver and issues
// one read or write request per well-formed line on the internal request bus.
module bridge_rx
    import bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            axiid,
    input  logic                  axiiv,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_data,
    output logic                  req_rw,
    output logic                  req_valid,
    input  logic                  req_ready
);

    localparam int NA    = ADDR_WIDTH / 4;
    localparam int ND    = DATA_WIDTH / 4;
    localparam int CNT_W = $clog2(NA + ND + 1);

    localparam logic [CNT_W-1:0] NA_CNT   = CNT_W'(NA);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NA + ND);

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      bytes_received;
    logic [CNT_W-1:0]      bytes_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] data_next;
    logic                  rw_next;
    logic                  valid_next;

    logic       is_term;
    logic       is_digit;
    logic [3:0] nibble;

    assign is_term  = (axiid == CHAR_CR) || (axiid == CHAR_LF);
    assign is_digit = is_hex(axiid);
    assign nibble   = hex_to_nibble(axiid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            bytes_received <= '0;
            req_addr       <= '0;
            req_data       <= '0;
            req_rw         <= 1'b0;
            req_valid      <= 1'b0;
        end else begin
            state          <= state_next;
            bytes_received <= bytes_next;
            req_addr       <= addr_next;
            req_data       <= data_next;
            req_rw         <= rw_next;
            req_valid      <= valid_next;
        end
    end

    // Address and data fields are never cleared on a new line; they only shift as digits arrive.
    always_comb begin
        state_next = state;
        bytes_next = bytes_received;
        addr_next  = req_addr;
        data_next  = req_data;
        rw_next    = req_rw;
        valid_next = req_valid;

        unique case (state)
            IDLE: begin
                valid_next = 1'b0;
                if (axiiv && axiid == CHAR_M) begin
                    state_next = ACQUIRE;
                    bytes_next = '0;
                end
            end

            ACQUIRE: begin
                if (axiiv) begin
                    if (is_digit) begin
                        if (bytes_received < NA_CNT) begin
                            addr_next  = {req_addr[ADDR_WIDTH-5:0], nibble};
                            bytes_next = bytes_received + 1'b1;
                        end else if (bytes_received < FULL_CNT) begin
                            data_next  = {req_data[DATA_WIDTH-5:0], nibble};
                            bytes_next = bytes_received + 1'b1;
                        end else begin
                            state_next = ERROR;
                        end
                    end else if (is_term) begin
                        if (bytes_received == NA_CNT) begin
                            rw_next    = 1'b0;
                            valid_next = 1'b1;
                            state_next = TRANSMIT;
                        end else if (bytes_received == FULL_CNT) begin
                            rw_next    = 1'b1;
                            valid_next = 1'b1;
                            state_next = TRANSMIT;
                        end else begin
                            state_next = ERROR;
                        end
                    end else begin
                        state_next = ERROR;
                    end
                end
            end

            TRANSMIT: begin
                valid_next = 1'b1;
                if (req_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end

            ERROR: begin
                valid_next = 1'b0;
                if (axiiv && axiid == CHAR_M) begin
                    state_next = ACQUIRE;
                    bytes_next = '0;
                end
            end

            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bridge_rx.sv
// Directed self-checking bench for bridge_rx: feeds ASCII command lines and
// checks the request bus against hand-computed values.
module tb_bridge_rx;
    import bridge_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  axiid;
    logic        axiiv;
    logic [15:0] req_addr;
    logic [15:0] req_data;
    logic        req_rw;
    logic        req_valid;
    logic        req_ready;

    int tests_run;
    int tests_failed;
    logic valid_seen;

    bridge_rx #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .axiid     (axiid),
        .axiiv     (axiiv),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_rw    (req_rw),
        .req_valid (req_valid),
        .req_ready (req_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One byte per cycle, driven on the falling edge and sampled 1ns after the rising edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        axiid = b;
        axiiv = 1'b1;
        @(posedge clk);
        #1;
        axiiv = 1'b0;
        valid_seen = valid_seen | req_valid;
    endtask

    task automatic send_str(input string s);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            send_byte(c);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ready();
        @(negedge clk);
        req_ready = 1'b1;
        @(posedge clk);
        #1;
        req_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        tests_run++;
        if (dut.state !== IDLE) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got %0d expected %0d", dut.state, IDLE);
        end
        tests_run++;
        if (req_addr !== 16'h0 || req_data !== 16'h0 || req_rw !== 1'b0 || req_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got addr=%h data=%h rw=%b valid=%b expected all 0",
                     req_addr, req_data, req_rw, req_valid);
        end
        tests_run++;
        if (dut.bytes_received !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_count: got %0d expected 0", dut.bytes_received);
        end
        repeat (2) idle_cycle();
        @(negedge clk);
        rst = 1'b1;
        idle_cycle();
    endtask

    task automatic test_write_crlf();
        valid_seen = 1'b0;
        send_str("M12345678");
        tests_run++;
        if (valid_seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL crlf_early_valid: got %b expected 0", valid_seen);
        end
        send_byte(CHAR_CR);
        tests_run++;
        if (req_addr !== 16'h1234 || req_data !== 16'h5678 || req_rw !== 1'b1 || req_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL crlf_write: got addr=%h data=%h rw=%b valid=%b expected 1234 5678 1 1",
                     req_addr, req_data, req_rw, req_valid);
        end
        pulse_ready();
        send_byte(CHAR_LF);
        tests_run++;
        if (dut.state !== IDLE || req_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL crlf_trailing_lf: got state=%0d valid=%b expected %0d 0",
                     dut.state, req_valid, IDLE);
        end
    endtask

    task automatic test_write_then_read();
        send_str("MDEADBEEF");
        send_byte(CHAR_CR);
        tests_run++;
        if (req_addr !== 16'hDEAD || req_data !== 16'hBEEF || req_rw !== 1'b1 || req_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wr_deadbeef: got addr=%h data=%h rw=%b valid=%b expected dead beef 1 1",
                     req_addr, req_data, req_rw, req_valid);
        end
        send_byte(CHAR_LF);
        pulse_ready();
        send_str("MBABE");
        send_byte(CHAR_CR);
        tests_run++;
        if (req_addr !== 16'hBABE || req_data !== 16'hBEEF || req_rw !== 1'b0 || req_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rd_babe: got addr=%h data=%h rw=%b valid=%b expected babe beef 0 1",
                     req_addr, req_data, req_rw, req_valid);
        end
        send_byte(CHAR_LF);
        pulse_ready();
    endtask

    task automatic test_single_terminators();
        send_str("M0000");
        send_byte(CHAR_CR);
        tests_run++;
        if (req_addr !== 16'h0000 || req_rw !== 1'b0 || req_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL cr_only_read: got addr=%h rw=%b valid=%b expected 0000 0 1",
                     req_addr, req_rw, req_valid);
        end
        pulse_ready();
        send_str("MF00DBEEF");
        send_byte(CHAR_LF);
        tests_run++;
        if (req_addr !== 16'hF00D || req_data !== 16'hBEEF || req_rw !== 1'b1 || req_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL lf_only_write: got addr=%h data=%h rw=%b valid=%b expected f00d beef 1 1",
                     req_addr, req_data, req_rw, req_valid);
        end
        pulse_ready();
    endtask

    task automatic test_length_errors();
        valid_seen = 1'b0;
        send_str("MABC");
        send_byte(CHAR_CR);
        tests_run++;
        if (dut.state !== ERROR) begin
            tests_failed++;
            $display("[TB] FAIL short_addr_state: got %0d expected %0d", dut.state, ERROR);
        end
        send_byte(CHAR_LF);
        tests_run++;
        if (dut.state !== ERROR) begin
            tests_failed++;
            $display("[TB] FAIL error_holds_lf: got %0d expected %0d", dut.state, ERROR);
        end
        send_str("M");
        send_byte(CHAR_CR);
        send_byte(CHAR_LF);
        tests_run++;
        if (dut.state !== ERROR) begin
            tests_failed++;
            $display("[TB] FAIL empty_line_state: got %0d expected %0d", dut.state, ERROR);
        end
        send_str("M123456789");
        tests_run++;
        if (dut.state !== ERROR) begin
            tests_failed++;
            $display("[TB] FAIL too_long_state: got %0d expected %0d", dut.state, ERROR);
        end
        send_byte(CHAR_CR);
        tests_run++;
        if (dut.state !== ERROR || valid_seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL length_no_valid: got state=%0d valid_seen=%b expected %0d 0",
                     dut.state, valid_seen, ERROR);
        end
    endtask

    task automatic test_invalid_chars();
        valid_seen = 1'b0;
        send_str("MABCG");
        tests_run++;
        if (dut.state !== ERROR) begin
            tests_failed++;
            $display("[TB] FAIL bad_char_g: got %0d expected %0d", dut.state, ERROR);
        end
        send_byte(CHAR_CR);
        send_byte(CHAR_LF);
        send_str("MABC[");
        tests_run++;
        if (dut.state !== ERROR) begin
            tests_failed++;
            $display("[TB] FAIL bad_char_bracket: got %0d expected %0d", dut.state, ERROR);
        end
        send_str("]()##*@");
        send_byte(CHAR_CR);
        send_byte(CHAR_LF);
        tests_run++;
        if (dut.state !== ERROR || valid_seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bad_char_no_valid: got state=%0d valid_seen=%b expected %0d 0",
                     dut.state, valid_seen, ERROR);
        end
        send_str("M1234");
        send_byte(CHAR_CR);
        tests_run++;
        if (req_addr !== 16'h1234 || req_rw !== 1'b0 || req_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL recover_read: got addr=%h rw=%b valid=%b expected 1234 0 1",
                     req_addr, req_rw, req_valid);
        end
        pulse_ready();
    endtask

    task automatic test_handshake();
        send_str("MB0BACAFE");
        send_byte(CHAR_CR);
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            tests_run++;
            if (req_addr !== 16'hB0BA || req_data !== 16'hCAFE || req_rw !== 1'b1 || req_valid !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL hold_stable[%0d]: got addr=%h data=%h rw=%b valid=%b expected b0ba cafe 1 1",
                         i, req_addr, req_data, req_rw, req_valid);
            end
        end
        send_str("M99");
        tests_run++;
        if (req_addr !== 16'hB0BA || req_valid !== 1'b1 || dut.state !== TRANSMIT) begin
            tests_failed++;
            $display("[TB] FAIL transmit_drops_bytes: got addr=%h valid=%b state=%0d expected b0ba 1 %0d",
                     req_addr, req_valid, dut.state, TRANSMIT);
        end
        pulse_ready();
        tests_run++;
        if (req_valid !== 1'b0 || dut.state !== IDLE || req_addr !== 16'hB0BA || req_data !== 16'hCAFE) begin
            tests_failed++;
            $display("[TB] FAIL ready_release: got valid=%b state=%0d addr=%h data=%h expected 0 %0d b0ba cafe",
                     req_valid, dut.state, req_addr, req_data, IDLE);
        end
    endtask

    task automatic test_reset_midline();
        send_str("M12");
        tests_run++;
        if (dut.state !== ACQUIRE) begin
            tests_failed++;
            $display("[TB] FAIL midline_acquire: got %0d expected %0d", dut.state, ACQUIRE);
        end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (dut.state !== IDLE || dut.bytes_received !== '0 || req_addr !== 16'h0 ||
            req_data !== 16'h0 || req_rw !== 1'b0 || req_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midline_reset: got state=%0d cnt=%0d addr=%h data=%h rw=%b valid=%b expected all 0",
                     dut.state, dut.bytes_received, req_addr, req_data, req_rw, req_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        valid_seen = 1'b0;
        send_str("34");
        send_byte(CHAR_CR);
        tests_run++;
        if (valid_seen !== 1'b0 || dut.state !== IDLE) begin
            tests_failed++;
            $display("[TB] FAIL midline_no_request: got valid_seen=%b state=%0d expected 0 %0d",
                     valid_seen, dut.state, IDLE);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        valid_seen   = 1'b0;
        axiid        = 8'h00;
        axiiv        = 1'b0;
        req_ready    = 1'b0;
        rst          = 1'b1;

        test_reset();
        test_write_crlf();
        test_write_then_read();
        test_single_terminators();
        test_length_errors();
        test_invalid_chars();
        test_handshake();
        test_reset_midline();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
